// File: rtl/pc_stack_if.sv
// pc_stack_if: decoder-side command strobes and PC/stack status
// master = instruction decoder, slave = pc_stack
interface pc_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             en;
   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic             call;
   logic             ret;
   logic             clr_err;
   logic [WIDTH-1:0] out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;

   modport master (
      output en, in, load, inc, call, ret, clr_err,
      input  out, count, empty, full, ovf, unf
   );

   modport slave (
      input  en, in, load, inc, call, ret, clr_err,
      output out, count, empty, full, ovf, unf
   );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with hardware return-address stack
// single-cycle call/ret, sticky overflow/underflow flags
module pc_stack #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input logic       clk,
   input logic       reset_n,
   pc_stack_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] out_q, out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;
   logic             empty, full;
   logic             sel_ret, sel_call;
   logic             sel_load, sel_inc;
   logic [IW-1:0]    top_idx, push_idx;
   logic [WIDTH-1:0] ret_addr, nxt_pc;
   logic [WIDTH-1:0] stack_q [DEPTH];

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CW'(DEPTH));
   assign push_idx = IW'(cnt_q);
   assign top_idx  = IW'(cnt_q - CW'(1));
   assign ret_addr = stack_q[top_idx];
   assign nxt_pc   = out_q + WIDTH'(1);

   // one-hot selects encode ret > call > load > inc
   assign sel_ret  = bus.en & bus.ret;
   assign sel_call = bus.en & bus.call & ~bus.ret;
   assign sel_load = bus.en & bus.load & ~bus.ret & ~bus.call;
   assign sel_inc  = bus.en & bus.inc & ~bus.ret & ~bus.call
                   & ~bus.load;

   always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q & ~bus.clr_err;
      unf_d = unf_q & ~bus.clr_err;
      push  = 1'b0;
      unique case (1'b1)
         sel_ret: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               out_d = ret_addr;
               cnt_d = cnt_q - CW'(1);
            end
         end
         sel_call: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push  = 1'b1;
               out_d = bus.in;
               cnt_d = cnt_q + CW'(1);
            end
         end
         sel_load: out_d = bus.in;
         sel_inc:  out_d = nxt_pc;
         default: ;
      endcase
   end

   // storage is deliberately unreset; count alone defines validity
   always_ff @(posedge clk) begin
      if (push) stack_q[push_idx] <= nxt_pc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= RESET_VEC;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.count = cnt_q;
   assign bus.empty = empty;
   assign bus.full  = full;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return-address stack, for the next-generation CPU core. It keeps the load/increment/hold behaviour of the basic PC, widens the address to WIDTH bits, and adds single-cycle call and return. Stack overflow and underflow are detected and flagged. The block sits between the instruction decoder (command strobes) and instruction memory (address `out`).

## Interface
- WIDTH, 16, address width in bits (≥2)
- DEPTH, 8, return-stack entries (≥1)
- RESET_VEC, 0, value loaded into `out` on reset (WIDTH bits)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset; one clock domain only
- en  input  1  advance enable; 0 = stall (PC, stack and error flags frozen)
- in  input  WIDTH  jump/call target
- load  input  1  jump: out ← in
- inc  input  1  increment: out ← out+1
- call  input  1  push out+1, then out ← in
- ret  input  1  pop: out ← top of stack
- clr_err  input  1  clear sticky ovf/unf (honoured even when en=0)
- out  output  WIDTH  current PC (registered)
- count  output  $clog2(DEPTH+1)  number of valid stack entries
- empty  output  1  count==0
- full  output  1  count==DEPTH
- ovf  output  1  sticky: call attempted while full
- unf  output  1  sticky: ret attempted while empty

## Operation
- Command priority per cycle when en=1: ret > call > load > inc > hold. Only the highest-priority asserted command acts; lower ones are ignored that cycle.
- ret, count>0: out ← stack[count-1], count ← count-1.
- ret, count==0: out holds, count holds, unf ← 1.
- call, count<DEPTH: stack[count] ← out+1 (mod 2^WIDTH), out ← in, count ← count+1.
- call, count==DEPTH: the call is dropped entirely (no push, no jump); out holds, ovf ← 1.
- load: out ← in; stack untouched.
- inc: out ← out+1; all-ones wraps to 0. No flag is raised on wrap.
- None asserted: out holds.
- Arithmetic is unsigned modulo 2^WIDTH. `in` is passed through bit-exact, so negative two's-complement targets are legal.
- en=0: no state changes, except clr_err.
- clr_err=1 clears ovf/unf. If clr_err and a new error event occur in the same cycle, the error wins and the flag ends at 1.
- Stack storage is not reset. Its contents are observable only through ret after a matching call.

## Timing
- Async reset: reset_n low immediately forces out=RESET_VEC, count=0, empty=1, full=0, ovf=0, unf=0, regardless of clk.
- While reset_n is low, all inputs are ignored.
- On reset_n deassertion, the first active edge is the first rising clk edge with reset_n high. The deassertion must meet recovery time relative to clk.
- Reset mid-sequence (e.g. during nested calls) discards the whole stack: count=0 afterwards, and the next ret flags unf.
- All updates occur on the rising clk edge. Latency is 1 cycle: a command sampled at edge N is visible on out/count after edge N.
- empty/full are decoded from registered count, so they change in the same cycle as count.
- call then ret on consecutive cycles returns to the call address + 1 with no bubble. Back-to-back calls up to DEPTH each take 1 cycle.
- Simultaneous call+ret: ret wins. If empty, unf is set and the call is ignored.

## Test plan
- Reset/inc wrap (WIDTH=16, RESET_VEC=0): pulse reset_n low between clk edges → out=0 asynchronously, empty=1. Then load in=16'hFFFE, then inc×2 → out=FFFF, then 0000; ovf=unf=0.
- Priority/stall: in=-32123, load=1, inc=1 → out=16'h8285. Then en=0 with inc=1 for 3 cycles → out stays 16'h8285. Then en=1, inc → 16'h8286.
- Nested call/ret (DEPTH=4): out=16'h0010, call in=0x0100 → out=0x0100, count=1. Then inc, call in=0x0200 → out=0x0200, count=2. Then ret → 0x0102. Then ret → 0x0011, count=0, empty=1.
- Overflow: 4 calls reach full=1. A 5th call in=0x0ABC → out unchanged, count=4, ovf=1. Then 4 rets return the pushed addresses in LIFO order. clr_err → ovf=0.
- Underflow/collision: count=0, ret=1 with call=1, in=0x0300 → out unchanged, count=0, unf=1. The next cycle, clr_err=1 together with ret=1 → unf remains 1.
- Reset mid-operation: after 3 calls, assert reset_n low mid-cycle → out=RESET_VEC, count=0 immediately. After release, ret → unf=1, out=RESET_VEC.
